// File: rtl/jtframe_sdram_sched_if.sv
// rtl/jtframe_sdram_sched_if.sv - request/command/strobe bundle of the SDRAM command scheduler
//
// Groups every non-clock signal of jtframe_sdram_sched:
//   prog side   : downloading, prog_rd, prog_we, prog_ba, prog_addr -> prog_ack/dst/rdy
//   bank side   : ba_rd[3:0], ba_wr, ba0..ba3_addr                  -> ba_ack/dst/rdy[3:0]
//   core side   : core_req, core_ba, core_addr, core_wr, core_rfsh <- core_ack/dst/rdy
// The "slave" modport is the scheduler's view; "master" is the requesters' and core's view.
interface jtframe_sdram_sched_if #(
  parameter int AW = 22
);
  logic          downloading;
  logic          prog_rd;
  logic          prog_we;
  logic [1:0]    prog_ba;
  logic [AW-1:0] prog_addr;
  logic          prog_ack;
  logic          prog_dst;
  logic          prog_rdy;

  logic [3:0]    ba_rd;
  logic          ba_wr;
  logic [AW-1:0] ba0_addr;
  logic [AW-1:0] ba1_addr;
  logic [AW-1:0] ba2_addr;
  logic [AW-1:0] ba3_addr;
  logic [3:0]    ba_ack;
  logic [3:0]    ba_dst;
  logic [3:0]    ba_rdy;

  logic          core_req;
  logic [1:0]    core_ba;
  logic [AW-1:0] core_addr;
  logic          core_wr;
  logic          core_rfsh;
  logic          core_ack;
  logic          core_dst;
  logic          core_rdy;

  modport slave (
    input  downloading, prog_rd, prog_we, prog_ba, prog_addr,
    output prog_ack, prog_dst, prog_rdy,
    input  ba_rd, ba_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
    output ba_ack, ba_dst, ba_rdy,
    output core_req, core_ba, core_addr, core_wr, core_rfsh,
    input  core_ack, core_dst, core_rdy
  );

  modport master (
    output downloading, prog_rd, prog_we, prog_ba, prog_addr,
    input  prog_ack, prog_dst, prog_rdy,
    output ba_rd, ba_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
    input  ba_ack, ba_dst, ba_rdy,
    input  core_req, core_ba, core_addr, core_wr, core_rfsh,
    output core_ack, core_dst, core_rdy
  );
endinterface

// File: rtl/jtframe_sdram_sched.sv
// rtl/jtframe_sdram_sched.sv - single-port SDRAM command scheduler (banks, prog, refresh)
//
// Grants one SDRAM command at a time to one of: four game bank requesters
// (round-robin), the ROM download port (exclusive while downloading), or an
// auto-refresh generator. Handshake strobes from the core are routed back to
// the current owner only.
//   clk    : system / SDRAM clock
//   rst_n  : asynchronous active-low reset
//   bus    : jtframe_sdram_sched_if.slave (requests in, command out, strobes back)
module jtframe_sdram_sched #(
  parameter int AW          = 22,
  parameter int RFSH_PERIOD = 750
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtframe_sdram_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int CW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RFSH_PERIOD - 1);

  // Owner encoding: bit 2 set means a game bank, bits [1:0] give its index.
  localparam logic [2:0] OWN_NONE = 3'd0;
  localparam logic [2:0] OWN_PROG = 3'd1;
  localparam logic [2:0] OWN_RFSH = 3'd2;

  state_t        state_q, state_d;
  logic [1:0]    rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rp_q, rp_d;
  logic [2:0]    owner_q, owner_d;
  logic [1:0]    ba_q, ba_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic          rfsh_q, rfsh_d;

  logic [3:0]    bank_req;
  logic          bank_hit;
  logic [1:0]    bank_sel;
  logic [AW-1:0] bank_addr;
  logic          cnt_wrap;
  logic          rfsh_done;
  logic [3:0]    ba_ack_c, ba_dst_c, ba_rdy_c;
  logic          prog_ack_c, prog_dst_c, prog_rdy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      cnt_q   <= '0;
      rp_q    <= 2'd0;
      owner_q <= OWN_NONE;
      ba_q    <= 2'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      rfsh_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      rp_q    <= rp_d;
      owner_q <= owner_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      rfsh_q  <= rfsh_d;
    end
  end

  // Round-robin search: descending loop so the smallest offset from rr wins.
  always_comb begin
    bank_req = bus.ba_rd | {3'b000, bus.ba_wr};
    bank_hit = 1'b0;
    bank_sel = rr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bank_req[rr_q + 2'(k)]) begin
        bank_hit = 1'b1;
        bank_sel = rr_q + 2'(k);
      end
    end
  end

  always_comb begin
    case (bank_sel)
      2'd0:    bank_addr = bus.ba0_addr;
      2'd1:    bank_addr = bus.ba1_addr;
      2'd2:    bank_addr = bus.ba2_addr;
      default: bank_addr = bus.ba3_addr;
    endcase
  end

  // Refresh token bookkeeping. A wrap and a refresh ack in the same cycle cancel.
  always_comb begin
    cnt_wrap  = (cnt_q == CNT_MAX);
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    rfsh_done = (state_q == ISSUE) && (owner_q == OWN_RFSH) && bus.core_ack;
    rp_d      = rp_q;
    if (cnt_wrap && !rfsh_done) begin
      if (rp_q != 2'd3) rp_d = rp_q + 2'd1;
    end else if (rfsh_done && !cnt_wrap) begin
      rp_d = rp_q - 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    ba_d       = ba_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    rfsh_d     = rfsh_q;
    ba_ack_c   = 4'd0;
    ba_dst_c   = 4'd0;
    ba_rdy_c   = 4'd0;
    prog_ack_c = 1'b0;
    prog_dst_c = 1'b0;
    prog_rdy_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (rp_q >= 2'd2) begin
          owner_d = OWN_RFSH;
          rfsh_d  = 1'b1;
          wr_d    = 1'b0;
          state_d = ISSUE;
        end else if (bus.downloading && (bus.prog_rd || bus.prog_we)) begin
          owner_d = OWN_PROG;
          rfsh_d  = 1'b0;
          ba_d    = bus.prog_ba;
          addr_d  = bus.prog_addr;
          wr_d    = bus.prog_we;
          state_d = ISSUE;
        end else if (!bus.downloading && bank_hit) begin
          owner_d = {1'b1, bank_sel};
          rfsh_d  = 1'b0;
          ba_d    = bank_sel;
          addr_d  = bank_addr;
          wr_d    = (bank_sel == 2'd0) && bus.ba_wr;
          state_d = ISSUE;
        end else if (rp_q != 2'd0) begin
          owner_d = OWN_RFSH;
          rfsh_d  = 1'b1;
          wr_d    = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.core_ack) begin
          if (owner_q[2]) begin
            ba_ack_c[owner_q[1:0]] = 1'b1;
            rr_d = owner_q[1:0] + 2'd1;
          end else if (owner_q == OWN_PROG) begin
            prog_ack_c = 1'b1;
          end
          state_d = (owner_q == OWN_RFSH) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (owner_q[2]) begin
          ba_dst_c[owner_q[1:0]] = bus.core_dst;
          ba_rdy_c[owner_q[1:0]] = bus.core_rdy;
        end else if (owner_q == OWN_PROG) begin
          prog_dst_c = bus.core_dst;
          prog_rdy_c = bus.core_rdy;
        end
        if (bus.core_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.core_req  = (state_q == ISSUE);
  assign bus.core_ba   = ba_q;
  assign bus.core_addr = addr_q;
  assign bus.core_wr   = wr_q;
  assign bus.core_rfsh = rfsh_q;
  assign bus.ba_ack    = ba_ack_c;
  assign bus.ba_dst    = ba_dst_c;
  assign bus.ba_rdy    = ba_rdy_c;
  assign bus.prog_ack  = prog_ack_c;
  assign bus.prog_dst  = prog_dst_c;
  assign bus.prog_rdy  = prog_rdy_c;

endmodule

// File: tb/tb_jtframe_sdram_sched.sv
// tb/tb_jtframe_sdram_sched.sv - scoreboard bench for jtframe_sdram_sched
module tb_jtframe_sdram_sched;

  localparam int AW = 22;
  localparam int RP = 64;

  typedef struct {
    bit             rfsh;
    bit             prog;
    logic [1:0]     ba;
    logic [AW-1:0]  addr;
    bit             wr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic [4:0] cur_strb;
  bit   cur_valid;
  bit   cur_rfsh;

  jtframe_sdram_sched_if #(.AW(AW)) bus();

  jtframe_sdram_sched #(.AW(AW), .RFSH_PERIOD(RP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_bank(input logic [1:0] ba, input logic [AW-1:0] addr, input bit wr);
    exp_t e;
    e.rfsh = 0; e.prog = 0; e.ba = ba; e.addr = addr; e.wr = wr;
    exp_q.push_back(e);
  endtask

  task automatic push_prog(input logic [1:0] ba, input logic [AW-1:0] addr, input bit wr);
    exp_t e;
    e.rfsh = 0; e.prog = 1; e.ba = ba; e.addr = addr; e.wr = wr;
    exp_q.push_back(e);
  endtask

  task automatic push_rfsh();
    exp_t e;
    e.rfsh = 1; e.prog = 0; e.ba = 2'd0; e.addr = '0; e.wr = 0;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.downloading = 0; bus.prog_rd = 0; bus.prog_we = 0; bus.prog_ba = 0; bus.prog_addr = 0;
    bus.ba_rd = 0; bus.ba_wr = 0;
    bus.ba0_addr = 22'h000100; bus.ba1_addr = 22'h011111;
    bus.ba2_addr = 22'h022222; bus.ba3_addr = 22'h033333;
    bus.core_ack = 0; bus.core_dst = 0; bus.core_rdy = 0;
    exp_q.delete();
    cur_valid = 0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic serve_ack(input int ack_dly);
    int t;
    exp_t e;
    logic [4:0] got;
    cur_valid = 0;
    t = 0;
    while (bus.core_req !== 1'b1 && t < 400) begin
      cyc(1);
      t++;
    end
    checks++;
    if (bus.core_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout core_req=%b required 1", bus.core_req);
      return;
    end
    cyc(ack_dly);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_cmd rfsh=%b ba=%0d addr=%h required no command",
               bus.core_rfsh, bus.core_ba, bus.core_addr);
      return;
    end
    e = exp_q.pop_front();
    if (bus.core_rfsh !== e.rfsh) begin
      errors++;
      $display("FAIL cmd_rfsh got=%b required %b", bus.core_rfsh, e.rfsh);
    end
    if (!e.rfsh) begin
      checks++;
      if ({bus.core_ba, bus.core_addr, bus.core_wr} !== {e.ba, e.addr, e.wr}) begin
        errors++;
        $display("FAIL cmd_fields got ba=%0d addr=%h wr=%b required ba=%0d addr=%h wr=%b",
                 bus.core_ba, bus.core_addr, bus.core_wr, e.ba, e.addr, e.wr);
      end
    end
    cur_rfsh = e.rfsh;
    cur_strb = e.rfsh ? 5'b00000 : (e.prog ? 5'b10000 : {1'b0, 4'b0001 << e.ba});
    bus.core_ack = 1'b1;
    #1;
    got = {bus.prog_ack, bus.ba_ack};
    checks++;
    if (got !== cur_strb) begin
      errors++;
      $display("FAIL ack_strobe got={prog,ba}=%b required %b", got, cur_strb);
    end
    @(posedge clk);
    #1;
    bus.core_ack = 1'b0;
    checks++;
    if (bus.core_req !== 1'b0) begin
      errors++;
      $display("FAIL req_after_ack core_req=%b required 0", bus.core_req);
    end
    cur_valid = 1;
  endtask

  task automatic serve_rdy(input int rdy_dly);
    logic [4:0] got;
    if (!cur_valid || cur_rfsh) return;
    cyc(rdy_dly);
    bus.core_dst = 1'b1;
    #1;
    got = {bus.prog_dst, bus.ba_dst};
    checks++;
    if (got !== cur_strb || {bus.prog_rdy, bus.ba_rdy} !== 5'b0) begin
      errors++;
      $display("FAIL dst_strobe got dst=%b rdy=%b required dst=%b rdy=00000",
               got, {bus.prog_rdy, bus.ba_rdy}, cur_strb);
    end
    @(posedge clk);
    #1;
    bus.core_dst = 1'b0;
    bus.core_rdy = 1'b1;
    #1;
    got = {bus.prog_rdy, bus.ba_rdy};
    checks++;
    if (got !== cur_strb) begin
      errors++;
      $display("FAIL rdy_strobe got={prog,ba}=%b required %b", got, cur_strb);
    end
    @(posedge clk);
    #1;
    bus.core_rdy = 1'b0;
  endtask

  task automatic serve(input int ack_dly, input int rdy_dly);
    serve_ack(ack_dly);
    serve_rdy(rdy_dly);
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.core_ack = 1'b1; bus.core_dst = 1'b1; bus.core_rdy = 1'b1;
    #2;
    checks++;
    if ({bus.core_req, bus.core_ba, bus.core_addr, bus.core_wr, bus.core_rfsh,
         bus.prog_ack, bus.prog_dst, bus.prog_rdy, bus.ba_ack, bus.ba_dst, bus.ba_rdy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs req=%b ba=%0d addr=%h wr=%b rfsh=%b required all 0",
               bus.core_req, bus.core_ba, bus.core_addr, bus.core_wr, bus.core_rfsh);
    end
    do_reset();
    cyc(2);
    checks++;
    if ({bus.core_req, bus.ba_ack, bus.prog_ack} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset req=%b ba_ack=%b required 0", bus.core_req, bus.ba_ack);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    cyc(2);
    bus.ba2_addr = 22'h012345;
    bus.ba_rd = 4'b0100;
    push_bank(2'd2, 22'h012345, 1'b0);
    cyc(1);
    checks++;
    if (bus.core_req !== 1'b1) begin
      errors++;
      $display("FAIL single_latency core_req=%b required 1", bus.core_req);
    end
    serve(3, 5);
    bus.ba_rd = 4'b0000;
    check_queue_empty("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.ba_rd = 4'hF;
    push_bank(2'd0, 22'h000100, 1'b0);
    push_bank(2'd1, 22'h011111, 1'b0);
    push_bank(2'd2, 22'h022222, 1'b0);
    push_bank(2'd3, 22'h033333, 1'b0);
    push_bank(2'd0, 22'h000100, 1'b0);
    push_bank(2'd1, 22'h011111, 1'b0);
    for (int i = 0; i < 6; i++) serve(0, 0);
    bus.ba_rd = 4'b0000;
    check_queue_empty("round_robin");
  endtask

  task automatic test_download();
    do_reset();
    bus.downloading = 1'b1;
    bus.ba_rd = 4'hF;
    bus.prog_we = 1'b1;
    bus.prog_ba = 2'd3;
    bus.prog_addr = 22'h3FFFFF;
    push_prog(2'd3, 22'h3FFFFF, 1'b1);
    serve_ack(1);
    bus.downloading = 1'b0;
    bus.prog_we = 1'b0;
    push_bank(2'd0, 22'h000100, 1'b0);
    serve_rdy(2);
    serve(0, 0);
    bus.ba_rd = 4'b0000;
    check_queue_empty("download");
  endtask

  task automatic test_bank0_write();
    do_reset();
    bus.ba0_addr = 22'h0ABCDE;
    bus.ba_wr = 1'b1;
    push_bank(2'd0, 22'h0ABCDE, 1'b1);
    serve(2, 1);
    bus.ba_wr = 1'b0;
    check_queue_empty("bank0_write");
  endtask

  task automatic test_refresh_idle();
    int n;
    do_reset();
    n = 0;
    while (bus.core_req !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n != RP + 1) begin
      errors++;
      $display("FAIL refresh_latency cycles=%0d required %0d", n, RP + 1);
    end
    push_rfsh();
    serve(2, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.core_req !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL refresh_extra core_req=%b at cycle %0d required 0", bus.core_req, i);
        break;
      end
    end
    check_queue_empty("refresh_idle");
  endtask

  task automatic test_refresh_preempt();
    do_reset();
    bus.ba_rd = 4'b0010;
    push_bank(2'd1, 22'h011111, 1'b0);
    serve(140, 0);
    push_rfsh();
    push_bank(2'd1, 22'h011111, 1'b0);
    serve(0, 0);
    serve(0, 0);
    bus.ba_rd = 4'b0000;
    push_rfsh();
    serve(0, 0);
    check_queue_empty("refresh_preempt");
  endtask

  task automatic test_refresh_saturate();
    do_reset();
    bus.ba_rd = 4'b0010;
    push_bank(2'd1, 22'h011111, 1'b0);
    serve(270, 0);
    push_rfsh();
    push_rfsh();
    push_bank(2'd1, 22'h011111, 1'b0);
    serve(0, 0);
    serve(0, 0);
    serve(0, 0);
    bus.ba_rd = 4'b0000;
    push_rfsh();
    serve(0, 0);
    check_queue_empty("refresh_saturate");
  endtask

  task automatic test_async_reset();
    int t;
    do_reset();
    bus.ba_rd = 4'b0010;
    push_bank(2'd1, 22'h011111, 1'b0);
    serve(0, 0);
    bus.ba_rd = 4'b0100;
    t = 0;
    while (bus.core_req !== 1'b1 && t < 50) begin
      cyc(1);
      t++;
    end
    bus.core_ack = 1'b1;
    #1;
    checks++;
    if (bus.ba_ack !== 4'b0100) begin
      errors++;
      $display("FAIL async_pre_ack ba_ack=%b required 0100", bus.ba_ack);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.core_req, bus.ba_ack, bus.prog_ack, bus.core_ba, bus.core_addr} !== '0) begin
      errors++;
      $display("FAIL async_reset req=%b ba_ack=%b ba=%0d addr=%h required all 0",
               bus.core_req, bus.ba_ack, bus.core_ba, bus.core_addr);
    end
    bus.core_ack = 1'b0;
    bus.ba_rd = 4'b0000;
    cyc(2);
    rst_n = 1'b1;
    bus.ba_rd = 4'hF;
    push_bank(2'd0, 22'h000100, 1'b0);
    serve(0, 0);
    bus.ba_rd = 4'b0000;
    check_queue_empty("async_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur_strb = 5'b0;
    cur_valid = 0;
    cur_rfsh = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_download();
    test_bank0_write();
    test_refresh_idle();
    test_refresh_preempt();
    test_refresh_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_sdram_sched.md
# jtframe_sdram_sched

Single-port SDRAM command scheduler between the game's four bank requesters, the ROM-download (prog) port and the SDRAM command core. It grants one command at a time and gives the prog port exclusive access while downloading. It rotates fairly among banks 0-3 in game mode and inserts periodic auto-refresh commands. Data buses (write data, read data) do not pass through this block; it only sequences commands and routes handshake strobes back to the owner.

## Interface
Parameters:
- AW, 22: SDRAM word-address width (23 for 64 MB builds).
- RFSH_PERIOD, 750: clk cycles between refresh tokens.

Ports:
- clk  in  1  system/SDRAM clock.
- rst_n  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM download active; only prog is served.
- prog_rd, prog_we  in  1 each  prog read / write request (level).
- prog_ba  in  2  prog target bank.
- prog_addr  in  AW  prog address.
- prog_ack, prog_dst, prog_rdy  out  1 each  prog handshake strobes.
- ba_rd  in  4  per-bank read request (level).
- ba_wr  in  1  bank 0 write request (level); banks 1-3 are read-only.
- ba0_addr..ba3_addr  in  AW each  per-bank address.
- ba_ack, ba_dst, ba_rdy  out  4  per-bank handshake strobes.
- core_req  out  1  command valid to SDRAM core.
- core_ba  out  2  command bank.
- core_addr  out  AW  command address.
- core_wr  out  1  1 = write, 0 = read.
- core_rfsh  out  1  command is auto-refresh (addr/ba/wr don't care).
- core_ack  in  1  core accepted command (1-cycle pulse).
- core_dst  in  1  first data word on bus (pulse).
- core_rdy  in  1  transfer complete (pulse).

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer rr=0; refresh counter 0; pending refresh tokens rp=0; owner register cleared.
- States: IDLE, ISSUE, WAIT.
- IDLE: evaluate requests and pick a winner, in priority order:
  1. Refresh, if rp≥2 (urgent).
  2. Prog, if downloading and (prog_rd|prog_we).
  3. Banks, only if !downloading. Bank i requests when ba_rd[i], or ba_wr for i=0. Search starts at rr and proceeds rr, rr+1, ... mod 4.
  4. Refresh, if rp≥1.
- On a win: latch owner, core_ba, core_addr, core_wr and core_rfsh; go to ISSUE. With no winner, stay in IDLE.
  - Prog: core_ba=prog_ba, core_wr=prog_we.
  - Bank i: core_ba=i, core_wr = (i==0 & ba_wr).
- ISSUE: core_req=1 and all command fields held stable until core_ack.
  - On core_ack, ack[owner] pulses in the same cycle (combinational).
  - Refresh: rp decrements; next state IDLE.
  - Otherwise next state WAIT.
  - If a bank grant is acked, rr becomes granted bank+1 mod 4.
- WAIT: dst[owner]=core_dst and rdy[owner]=core_rdy, combinationally. core_rdy moves the state to IDLE.
- Requests are sampled only in IDLE. Once granted, a command completes even if the requester drops its request or downloading toggles. A change of downloading affects only the next IDLE decision.
- Refresh counter: free-running 0..RFSH_PERIOD-1.
  - At wrap, rp increments, saturating at 3.
  - If a wrap and a refresh ack happen in the same cycle, rp is unchanged.
- No strobe is ever routed to a non-owner. Strobes from the core outside ISSUE/WAIT are ignored.
- Reset mid-command: all state clears immediately. The core is expected to be reset by the same rst_n.

## Timing
- Request seen in IDLE at cycle N → core_req high at N+1.
- core_ack at cycle M → ba_ack/prog_ack high at M; core_req low at M+1.
- core_rdy at cycle K → rdy strobe at K; IDLE at K+1; next core_req no earlier than K+2.
- Refresh: ack at M → IDLE at M+1.
- Starvation bound: with all four banks requesting, each bank is granted at least once per 4 bank commands, plus at most one interleaved refresh per bank command.

## Test plan
- Single read: ba_rd=4'b0100, ba2_addr=0x12345, core acks after 3 cycles and gives rdy 5 cycles later → core_req 1 cycle after request, core_ba=2, core_addr=0x12345, core_wr=0, ba_ack[2] and ba_rdy[2] coincide with the core pulses, no other strobes.
- Round-robin: ba_rd=4'hF held, core acks and completes each command immediately → grant order 0,1,2,3,0,1 and rr wraps correctly.
- Download priority: downloading=1, ba_rd=4'hF, prog_we=1, prog_ba=3, prog_addr=0x3FFFFF → only prog granted with core_wr=1, core_ba=3; ba_ack stays 0. Dropping downloading mid-WAIT completes the prog command, then bank 0 is granted.
- Bank 0 write: ba_wr=1, ba_rd=0 → core_wr=1, core_ba=0; ba_wr attempted on another bank index is impossible by construction.
- Refresh: RFSH_PERIOD=8, no requests → refresh command after 8 cycles, rp back to 0. With banks busy until two tokens accrue, refresh preempts at the next IDLE. Saturation holds rp=3.
- Async reset: assert rst_n=0 during ISSUE → core_req and every strobe go to 0 immediately with no clock edge; after release, rr=0 and the first grant goes to bank 0.
